if_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC and drives the instruction ROM (ce_o, pc_o).

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 58 +++++
 rtl/if_stage.sv | 99 +++++++++
 tb/tb_if_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and selector enums for the instruction-fetch stage.
// Optional build macro used by this slice: IF_ALIGN_CHK_EN (fetch alignment check).
package if_stage_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;

  // Source of the next PC, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    PC_BOOT,
    PC_FLUSH,
    PC_HOLD,
    PC_PEND,
    PC_BRANCH,
    PC_SEQ
  } pc_sel_e;

  typedef enum logic [1:0] {
    ID_BUBBLE,
    ID_HOLD,
    ID_LOAD
  } id_op_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, hold and bubble rules.
// With IF_ALIGN_CHK_EN defined it also flags misaligned fetches on id_adel.
module if_id_reg import if_stage_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
`ifdef IF_ALIGN_CHK_EN
  output logic              id_adel,
`endif
  output logic              id_valid
);

  id_op_e op;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    op = ID_LOAD;
    if (flush) op = ID_BUBBLE;
    else if (stall_if == STOP && stall_id == STOP) op = ID_HOLD;
    else if (stall_if == STOP) op = ID_BUBBLE;
    else if (ce == CHIP_DISABLE) op = ID_BUBBLE;
  end

  // ID_HOLD simply leaves every register untouched.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || op == ID_BUBBLE) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
`ifdef IF_ALIGN_CHK_EN
      id_adel  <= 1'b0;
`endif
    end else if (op == ID_LOAD) begin
      id_pc    <= pc;
      id_valid <= 1'b1;
`ifdef IF_ALIGN_CHK_EN
      id_adel  <= |pc[1:0];
      id_inst  <= (|pc[1:0]) ? '0 : inst;
`else
      id_inst  <= inst;
`endif
    end
  end

  // The stall controller never holds decode while fetch runs.
  assert property (@(posedge clk) disable iff (rst) !(stall_id && !stall_if));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, pending-branch register, next-PC mux and IF/ID register.
// Build macro IF_ALIGN_CHK_EN: keep misaligned PCs and report them on id_adel_o instead of masking.
module if_stage import if_stage_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              ce_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
`ifdef IF_ALIGN_CHK_EN
  output logic              id_adel_o,
`endif
  output logic              id_valid_o
);

  logic              pend_vld;
  logic [ADDR_W-1:0] pend_tgt;
  pc_sel_e           pc_sel;

  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] a);
`ifdef IF_ALIGN_CHK_EN
    return a;
`else
    return a & ~ADDR_W'(3);
`endif
  endfunction

  always_comb begin
    pc_sel = PC_SEQ;
    if (ce_o == CHIP_DISABLE) pc_sel = PC_BOOT;
    else if (flush) pc_sel = PC_FLUSH;
    else if (stall_if == STOP) pc_sel = PC_HOLD;
    else if (pend_vld) pc_sel = PC_PEND;
    else if (branch_flag_i) pc_sel = PC_BRANCH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ce_o     <= CHIP_DISABLE;
      pc_o     <= RESET_PC;
      pend_vld <= 1'b0;
      pend_tgt <= '0;
    end else begin
      ce_o <= CHIP_ENABLE;
      unique case (pc_sel)
        PC_BOOT:   pc_o <= RESET_PC;
        PC_FLUSH: begin
          pc_o     <= fetch_addr(new_pc);
          pend_vld <= 1'b0;
        end
        // A branch resolved during a stall is parked until fetch resumes.
        PC_HOLD: if (branch_flag_i) begin
          pend_vld <= 1'b1;
          pend_tgt <= branch_target_i;
        end
        PC_PEND: begin
          pc_o     <= fetch_addr(pend_tgt);
          pend_vld <= 1'b0;
        end
        PC_BRANCH: pc_o <= fetch_addr(branch_target_i);
        default:   pc_o <= pc_o + ADDR_W'(PC_STEP);
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .stall_if (stall_if),
    .stall_id (stall_id),
    .flush    (flush),
    .ce       (ce_o),
    .pc       (pc_o),
    .inst     (inst_i),
    .id_pc    (id_pc_o),
    .id_inst  (id_inst_o),
`ifdef IF_ALIGN_CHK_EN
    .id_adel  (id_adel_o),
`endif
    .id_valid (id_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand sequences, random run vs. model.
// Works with or without IF_ALIGN_CHK_EN defined.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_if = 1'b0;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] inst_i;
  logic        ce_o;
  logic [31:0] pc_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
`ifdef IF_ALIGN_CHK_EN
  logic        id_adel_o;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF ^ {a[15:0], a[31:16]};
  endfunction

  assign inst_i = rom(pc_o);

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_i          (inst_i),
    .ce_o            (ce_o),
    .pc_o            (pc_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
`ifdef IF_ALIGN_CHK_EN
    .id_adel_o       (id_adel_o),
`endif
    .id_valid_o      (id_valid_o)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state of the fetch stage, pending redirect kept as a queue.
  bit          m_ce, m_id_valid, m_adel;
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  logic [31:0] pend_q[$];

  function automatic logic [31:0] loaded(input logic [31:0] a);
`ifdef IF_ALIGN_CHK_EN
    return a;
`else
    return (a / 4) * 4;
`endif
  endfunction

  task automatic model_step(input bit r, input bit si, input bit sd, input bit fl,
                            input logic [31:0] npc, input bit br, input logic [31:0] tgt);
    if (r) begin
      m_ce = 0; m_pc = 0; m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_adel = 0;
      pend_q.delete();
      return;
    end
    if (fl || (si && !sd) || !m_ce) begin
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_adel = 0;
    end else if (!si) begin
      m_id_pc = m_pc; m_id_valid = 1; m_id_inst = rom(m_pc); m_adel = 0;
`ifdef IF_ALIGN_CHK_EN
      if (m_pc % 4 != 0) begin m_id_inst = 0; m_adel = 1; end
`endif
    end
    if (!m_ce) m_pc = 0;
    else if (fl) begin
      m_pc = loaded(npc);
      pend_q.delete();
    end else if (si) begin
      if (br) begin pend_q.delete(); pend_q.push_back(tgt); end
    end else if (pend_q.size() != 0) m_pc = loaded(pend_q.pop_front());
    else if (br) m_pc = loaded(tgt);
    else m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    m_ce = 1;
  endtask

  task automatic compare_model();
    check("ce_o", 32'(ce_o), 32'(m_ce));
    check("pc_o", pc_o, m_pc);
    check("id_pc_o", id_pc_o, m_id_pc);
    check("id_inst_o", id_inst_o, m_id_inst);
    check("id_valid_o", 32'(id_valid_o), 32'(m_id_valid));
`ifdef IF_ALIGN_CHK_EN
    check("id_adel_o", 32'(id_adel_o), 32'(m_adel));
`endif
  endtask

  task automatic tick(input bit r, input bit si, input bit sd, input bit fl,
                      input logic [31:0] npc, input bit br, input logic [31:0] tgt);
    rst = r; stall_if = si; stall_id = sd; flush = fl;
    new_pc = npc; branch_flag_i = br; branch_target_i = tgt;
    model_step(r, si, sd, fl, npc, br, tgt);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit          r, si, sd, fl;
    logic [31:0] npc;
    bit          br;
    logic [31:0] tgt;
    bit          e_ce;
    logic [31:0] e_pc, e_id_pc;
    bit          e_valid;
  } vec_t;

  function automatic vec_t v(input bit r, input bit si, input bit sd, input bit fl,
                             input logic [31:0] npc, input bit br, input logic [31:0] tgt,
                             input bit e_ce, input logic [31:0] e_pc,
                             input logic [31:0] e_id_pc, input bit e_valid);
    vec_t x;
    x.r = r; x.si = si; x.sd = sd; x.fl = fl; x.npc = npc; x.br = br; x.tgt = tgt;
    x.e_ce = e_ce; x.e_pc = e_pc; x.e_id_pc = e_id_pc; x.e_valid = e_valid;
    return x;
  endfunction

  vec_t vecs[24];

  initial begin
    // Boot: three reset cycles, then one cycle with ce_o low, then fetch 0, 4, 8.
    vecs[0]  = v(1, 0, 0, 0, 0,     0, 0,      0, 32'h0,   32'h0,   0);
    vecs[1]  = v(1, 0, 0, 0, 0,     0, 0,      0, 32'h0,   32'h0,   0);
    vecs[2]  = v(1, 0, 0, 0, 0,     0, 0,      0, 32'h0,   32'h0,   0);
    vecs[3]  = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h0,   32'h0,   0);
    vecs[4]  = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h4,   32'h0,   1);
    vecs[5]  = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h8,   32'h4,   1);
    // Branch taken while pc_o = 8.
    vecs[6]  = v(0, 0, 0, 0, 0,     1, 32'h100, 1, 32'h100, 32'h8,   1);
    vecs[7]  = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h104, 32'h100, 1);
    // Branch arrives in the first of three full-stall cycles.
    vecs[8]  = v(0, 1, 1, 0, 0,     1, 32'h200, 1, 32'h104, 32'h100, 1);
    vecs[9]  = v(0, 1, 1, 0, 0,     0, 0,      1, 32'h104, 32'h100, 1);
    vecs[10] = v(0, 1, 1, 0, 0,     0, 0,      1, 32'h104, 32'h100, 1);
    vecs[11] = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h200, 32'h104, 1);
    vecs[12] = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h204, 32'h200, 1);
    // Flush beats a same-cycle branch.
    vecs[13] = v(0, 0, 0, 1, 32'h20, 1, 32'h300, 1, 32'h20, 32'h0,   0);
    vecs[14] = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h24,  32'h20,  1);
    // Flush discards a parked branch.
    vecs[15] = v(0, 1, 1, 0, 0,     1, 32'h400, 1, 32'h24, 32'h20,  1);
    vecs[16] = v(0, 1, 1, 1, 32'h40, 0, 0,     1, 32'h40,  32'h0,   0);
    vecs[17] = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h44,  32'h40,  1);
    // Fetch-only stall inserts a bubble.
    vecs[18] = v(0, 1, 0, 0, 0,     0, 0,      1, 32'h44,  32'h0,   0);
    vecs[19] = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h48,  32'h44,  1);
    // Reset while a branch is parked: nothing survives.
    vecs[20] = v(0, 1, 1, 0, 0,     1, 32'h500, 1, 32'h48, 32'h44,  1);
    vecs[21] = v(1, 0, 0, 0, 0,     0, 0,      0, 32'h0,   32'h0,   0);
    vecs[22] = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h0,   32'h0,   0);
    vecs[23] = v(0, 0, 0, 0, 0,     0, 0,      1, 32'h4,   32'h0,   1);

    for (int i = 0; i < 24; i++) begin
      tick(vecs[i].r, vecs[i].si, vecs[i].sd, vecs[i].fl, vecs[i].npc, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d ce_o", i), 32'(ce_o), 32'(vecs[i].e_ce));
      check($sformatf("vec%0d pc_o", i), pc_o, vecs[i].e_pc);
      check($sformatf("vec%0d id_pc_o", i), id_pc_o, vecs[i].e_id_pc);
      check($sformatf("vec%0d id_valid_o", i), 32'(id_valid_o), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d id_inst_o", i), id_inst_o,
            vecs[i].e_valid ? rom(vecs[i].e_id_pc) : 32'h0);
    end

    // Wrap from the top of the address space.
    tick(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check("wrap load", pc_o, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0, 0, 0, 0);
    check("wrap pc", pc_o, 32'h0);
    check("wrap id_pc", id_pc_o, 32'hFFFF_FFFC);

    // Misaligned branch target.
    tick(0, 0, 0, 0, 0, 1, 32'h102);
`ifdef IF_ALIGN_CHK_EN
    check("misalign pc", pc_o, 32'h102);
    tick(0, 0, 0, 0, 0, 0, 0);
    check("misalign adel", 32'(id_adel_o), 32'h1);
    check("misalign inst", id_inst_o, 32'h0);
    check("misalign valid", 32'(id_valid_o), 32'h1);
`else
    check("misalign pc", pc_o, 32'h100);
    tick(0, 0, 0, 0, 0, 0, 0);
    check("misalign id_pc", id_pc_o, 32'h100);
    check("misalign inst", id_inst_o, rom(32'h100));
`endif

    // Random legal traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int s;
      bit r, si, sd, fl, br;
      s  = int'($urandom_range(0, 9));
      si = (s >= 6);
      sd = (s == 6 || s == 7);
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 19) == 0);
      br = ($urandom_range(0, 4) == 0);
      tick(r, si, sd, fl, $urandom, br, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
